// File: rtl/mips_defines.sv
// Shared MIPS pipeline definitions: register file widths, memory op codes and
// the MEM-stage FSM state encoding.
package mips_defines;

    localparam int REG_ADDR_WIDTH = 5;
    localparam int REG_DATA_WIDTH = 32;

    typedef enum logic [3:0] {
        OP_NOP = 4'd0,
        OP_LB  = 4'd1,
        OP_LBU = 4'd2,
        OP_LH  = 4'd3,
        OP_LHU = 4'd4,
        OP_LW  = 4'd5,
        OP_SB  = 4'd6,
        OP_SH  = 4'd7,
        OP_SW  = 4'd8
    } mem_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2,
        ST_ERR  = 2'd3
    } mem_state_e;

endpackage

// File: rtl/mem_align.sv
// Combinational lane logic for the MEM stage: store byte enables and lane
// replication, load lane selection with sign/zero extension, misalignment.
module mem_align
    import mips_defines::*;
(
    input  logic [3:0]  i_op,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_load_data,
    output logic        o_misalign,
    output logic        o_is_mem,
    output logic        o_is_load,
    output logic        o_is_store
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        case (i_addr_lo)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase
        w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
    end

    always_comb begin
        o_be        = 4'b0000;
        o_wdata     = 32'h0;
        o_load_data = i_rdata;
        o_misalign  = 1'b0;
        o_is_mem    = 1'b1;
        o_is_load   = 1'b0;
        o_is_store  = 1'b0;
        case (i_op)
            OP_LB: begin
                o_is_load   = 1'b1;
                o_load_data = {{24{w_byte[7]}}, w_byte};
            end
            OP_LBU: begin
                o_is_load   = 1'b1;
                o_load_data = {24'h0, w_byte};
            end
            OP_LH: begin
                o_is_load   = 1'b1;
                o_misalign  = i_addr_lo[0];
                o_load_data = {{16{w_half[15]}}, w_half};
            end
            OP_LHU: begin
                o_is_load   = 1'b1;
                o_misalign  = i_addr_lo[0];
                o_load_data = {16'h0, w_half};
            end
            OP_LW: begin
                o_is_load  = 1'b1;
                o_misalign = |i_addr_lo;
            end
            OP_SB: begin
                o_is_store = 1'b1;
                o_be       = 4'b0001 << i_addr_lo;
                o_wdata    = {4{i_wdata[7:0]}};
            end
            OP_SH: begin
                o_is_store = 1'b1;
                o_misalign = i_addr_lo[0];
                o_be       = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_wdata    = {2{i_wdata[15:0]}};
            end
            OP_SW: begin
                o_is_store = 1'b1;
                o_misalign = |i_addr_lo;
                o_be       = 4'b1111;
                o_wdata    = i_wdata;
            end
            default: o_is_mem = 1'b0;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MIPS MEM stage: issues load/store on the req/ack data bus, stalls the
// pipeline while a transaction is in flight and formats load results.
module mem_stage
    import mips_defines::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [3:0]                mem_op_in,
    input  logic [31:0]               mem_addr_in,
    input  logic [31:0]               mem_wdata_in,
    input  logic [REG_ADDR_WIDTH-1:0] w_reg_addr_in,
    input  logic [REG_DATA_WIDTH-1:0] w_reg_data_in,
    input  logic                      w_reg_en_in,
    output logic [REG_ADDR_WIDTH-1:0] w_reg_addr_out,
    output logic [REG_DATA_WIDTH-1:0] w_reg_data_out,
    output logic                      w_reg_en_out,
    output logic                      stall_req,
    output logic                      dmem_req,
    output logic                      dmem_we,
    output logic [31:0]               dmem_addr,
    output logic [3:0]                dmem_be,
    output logic [31:0]               dmem_wdata,
    input  logic [31:0]               dmem_rdata,
    input  logic                      dmem_ack,
    output logic                      align_err,
    output logic                      bus_err
);

    mem_state_e       r_state;
    mem_state_e       w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_load_data;
    logic             r_req;
    logic             r_we;
    logic [3:0]       r_be;
    logic [31:0]      r_addr;
    logic [31:0]      r_wdata;

    logic [3:0]       w_be;
    logic [31:0]      w_wdata;
    logic [31:0]      w_load_fmt;
    logic             w_misalign;
    logic             w_is_mem;
    logic             w_is_load;
    logic             w_is_store;
    logic             w_issue;
    logic             w_timeout;

    // ex_mem holds op/addr stable while stalled, so DONE formats from the live inputs.
    mem_align u_align (
        .i_op        (mem_op_in),
        .i_addr_lo   (mem_addr_in[1:0]),
        .i_wdata     (mem_wdata_in),
        .i_rdata     (r_load_data),
        .o_be        (w_be),
        .o_wdata     (w_wdata),
        .o_load_data (w_load_fmt),
        .o_misalign  (w_misalign),
        .o_is_mem    (w_is_mem),
        .o_is_load   (w_is_load),
        .o_is_store  (w_is_store)
    );

    assign w_issue   = (r_state == ST_IDLE) && w_is_mem && !w_misalign;
    assign w_timeout = (r_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_issue) w_next = ST_BUSY;
            ST_BUSY: begin
                if (dmem_ack)       w_next = ST_DONE;
                else if (w_timeout) w_next = ST_ERR;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_req       <= 1'b0;
            r_we        <= 1'b0;
            r_be        <= 4'b0000;
            r_addr      <= 32'h0;
            r_wdata     <= 32'h0;
            r_cnt       <= '0;
            r_load_data <= 32'h0;
        end else if (w_issue) begin
            r_req   <= 1'b1;
            r_we    <= w_is_store;
            r_be    <= w_be;
            r_addr  <= {mem_addr_in[31:2], 2'b00};
            r_wdata <= w_wdata;
            r_cnt   <= '0;
        end else if (r_state == ST_BUSY) begin
            r_cnt <= r_cnt + 1'b1;
            // Ack takes priority over a simultaneous timeout.
            if (dmem_ack) begin
                r_load_data <= dmem_rdata;
                r_req       <= 1'b0;
            end else if (w_timeout) begin
                r_req <= 1'b0;
            end
        end
    end

    always_comb begin
        w_reg_addr_out = w_reg_addr_in;
        w_reg_data_out = w_reg_data_in;
        w_reg_en_out   = 1'b0;
        stall_req      = 1'b0;
        align_err      = 1'b0;
        bus_err        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_is_mem)       w_reg_en_out = w_reg_en_in;
                else if (w_misalign) align_err    = 1'b1;
                else                 stall_req    = 1'b1;
            end
            ST_BUSY: stall_req = 1'b1;
            ST_DONE: begin
                if (w_is_load) begin
                    w_reg_data_out = w_load_fmt;
                    w_reg_en_out   = w_reg_en_in;
                end
            end
            default: bus_err = 1'b1;
        endcase
        if (!rst_n) begin
            w_reg_addr_out = '0;
            w_reg_data_out = '0;
            w_reg_en_out   = 1'b0;
            stall_req      = 1'b0;
            align_err      = 1'b0;
            bus_err        = 1'b0;
        end
    end

    assign dmem_req   = r_req;
    assign dmem_we    = r_we;
    assign dmem_be    = r_be;
    assign dmem_addr  = r_addr;
    assign dmem_wdata = r_wdata;

endmodule
